// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the dual-channel sample capture buffer and the
// downstream cross-correlator: buffer geometry, ADC code conventions, the
// capture FSM state type and the trigger magnitude helper.
// No ports (package).
// -----------------------------------------------------------------------------
package capture_pkg;

    // Buffer geometry and ADC conventions, shared with the correlator
    localparam int DEPTH    = 2000;
    localparam int W        = 10;
    localparam int ADDR_W   = 12;
    localparam int MIDSCALE = 512;

    // Index width actually needed to address DEPTH RAM entries
    localparam int RAM_AW = $clog2(DEPTH);

    // Midscale code widened to the signed magnitude arithmetic width
    localparam logic [W:0] MIDSCALE_EXT = (W+1)'(MIDSCALE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FULL    = 2'd3
    } capture_state_t;

    // Distance of an unsigned ADC code from midscale. The subtraction is done
    // in W+1-bit signed arithmetic so codes below midscale go negative
    // cleanly; the largest possible distance (MIDSCALE itself) still fits.
    function automatic logic [W:0] sample_mag(input logic [W-1:0] s);
        logic signed [W:0] diff;
        diff = $signed({1'b0, s}) - $signed(MIDSCALE_EXT);
        if (diff < 0) begin
            return $unsigned(-diff);
        end
        return $unsigned(diff);
    endfunction

endpackage

// File: rtl/dual_sample_capture_if.sv
// -----------------------------------------------------------------------------
// dual_sample_capture_if
// Groups the capture buffer's control, sample and read-port signals.
//   master : producer/correlator side (drives arm, samples, threshold, rd_addr)
//   slave  : capture buffer side (drives read data and status)
// Signals:
//   arm, threshold, sample_valid, sample_a, sample_b, rd_addr  -> buffer
//   rd_a, rd_b, count, capturing, full                         <- buffer
// -----------------------------------------------------------------------------
interface dual_sample_capture_if;
    import capture_pkg::*;

    logic              arm;
    logic [W-1:0]      threshold;
    logic              sample_valid;
    logic [W-1:0]      sample_a;
    logic [W-1:0]      sample_b;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_a;
    logic [W-1:0]      rd_b;
    logic [ADDR_W-1:0] count;
    logic              capturing;
    logic              full;

    modport master (
        output arm, threshold, sample_valid, sample_a, sample_b, rd_addr,
        input  rd_a, rd_b, count, capturing, full
    );

    modport slave (
        input  arm, threshold, sample_valid, sample_a, sample_b, rd_addr,
        output rd_a, rd_b, count, capturing, full
    );

endinterface

// File: rtl/sample_ram.sv
// -----------------------------------------------------------------------------
// sample_ram
// One-write / one-read synchronous RAM, DEPTH_P x WIDTH_P, written so that it
// maps onto a block RAM (no reset, registered read data).
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data, one cycle after raddr
// Addresses beyond DEPTH_P-1 return undefined contents; the parent masks them.
// -----------------------------------------------------------------------------
module sample_ram #(
    parameter int DEPTH_P = 2000,
    parameter int WIDTH_P = 10,
    parameter int AW_P    = 11
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW_P-1:0]    waddr,
    input  logic [WIDTH_P-1:0] wdata,
    input  logic [AW_P-1:0]    raddr,
    output logic [WIDTH_P-1:0] rdata
);

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [WIDTH_P-1:0] rdata_q;

    // Plain write-port / registered-read-port body; leaving out any reset keeps
    // it recognisable as a block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dual_sample_capture.sv
// -----------------------------------------------------------------------------
// dual_sample_capture
// Two-channel triggered capture buffer feeding the cross-correlator. Once
// armed it waits for either channel to move further than `threshold` from
// midscale, then stores exactly DEPTH consecutive valid sample pairs and
// reports `full`; the stored pairs are then read through a registered port.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   bus      slave side of dual_sample_capture_if (arm, threshold, samples,
//            rd_addr in; rd_a, rd_b, count, capturing, full out)
// -----------------------------------------------------------------------------
module dual_sample_capture
    import capture_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    dual_sample_capture_if.slave bus
);

    capture_state_t    state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              rd_in_range_q;

    logic              wr_en;
    logic [RAM_AW-1:0] wr_addr;
    logic              trigger;
    logic [W-1:0]      ram_a_rdata;
    logic [W-1:0]      ram_b_rdata;

    // A pair triggers when it is valid and either channel is strictly further
    // from midscale than the threshold.
    assign trigger = bus.sample_valid &&
                     ((sample_mag(bus.sample_a) > {1'b0, bus.threshold}) ||
                      (sample_mag(bus.sample_b) > {1'b0, bus.threshold}));

    // State, pair count and the read-range flag. The range flag follows the
    // RAM's one-cycle read latency so the mask lines up with the data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            rd_in_range_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_in_range_q <= (bus.rd_addr < ADDR_W'(DEPTH));
        end
    end

    // Next-state and write control. A trigger outranks a simultaneous arm in
    // ARMED, and arm is ignored in CAPTURE so a capture always completes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            ARMED: begin
                if (trigger) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_d = ADDR_W'(1);
                    state_d = CAPTURE;
                end else if (bus.arm) begin
                    count_d = '0;
                end
            end
            CAPTURE: begin
                if (bus.sample_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = count_q[RAM_AW-1:0];
                    count_d = count_q + ADDR_W'(1);
                    if (count_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.arm) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    sample_ram #(
        .DEPTH_P (DEPTH),
        .WIDTH_P (W),
        .AW_P    (RAM_AW)
    ) u_ram_a (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.sample_a),
        .raddr (bus.rd_addr[RAM_AW-1:0]),
        .rdata (ram_a_rdata)
    );

    sample_ram #(
        .DEPTH_P (DEPTH),
        .WIDTH_P (W),
        .AW_P    (RAM_AW)
    ) u_ram_b (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.sample_b),
        .raddr (bus.rd_addr[RAM_AW-1:0]),
        .rdata (ram_b_rdata)
    );

    // Out-of-range reads, and the cycle right after reset, present zero.
    assign bus.rd_a      = rd_in_range_q ? ram_a_rdata : '0;
    assign bus.rd_b      = rd_in_range_q ? ram_b_rdata : '0;
    assign bus.count     = count_q;
    assign bus.capturing = (state_q == CAPTURE);
    assign bus.full      = (state_q == FULL);

endmodule

// File: tb/tb_dual_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_dual_sample_capture
// Directed self-checking bench for dual_sample_capture: reset, trigger
// threshold, full capture with gapped valid, read sweep, re-arm behaviour and
// reset during a capture.
// -----------------------------------------------------------------------------
module tb_dual_sample_capture;
    import capture_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    dual_sample_capture_if bus ();

    dual_sample_capture dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are stable #1 after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ramp pattern stored at address k >= 1: A = k, B = 1023 - k, both 10-bit.
    function automatic logic [9:0] ramp_a(input int k);
        return k[9:0];
    endfunction

    function automatic logic [9:0] ramp_b(input int k);
        int v;
        v = 1023 - k;
        return v[9:0];
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.arm          = 1'($urandom_range(0, 1));
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample_a     = 10'($urandom_range(0, 1023));
            bus.sample_b     = 10'($urandom_range(0, 1023));
            bus.threshold    = 10'($urandom_range(0, 1023));
            bus.rd_addr      = 12'($urandom_range(0, 4095));
            tick();
        end
        total++;
        if (bus.rd_a !== 10'd0) begin bad++; $display("[TB] FAIL reset_rd_a: got %0d expected 0", bus.rd_a); end
        total++;
        if (bus.rd_b !== 10'd0) begin bad++; $display("[TB] FAIL reset_rd_b: got %0d expected 0", bus.rd_b); end
        total++;
        if (bus.count !== 12'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        total++;
        if (bus.capturing !== 1'b0) begin bad++; $display("[TB] FAIL reset_capturing: got %0b expected 0", bus.capturing); end
        total++;
        if (bus.full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.full); end

        reset_n          = 1'b1;
        bus.arm          = 1'b0;
        bus.threshold    = 10'd10;
        bus.rd_addr      = '0;
        for (int i = 0; i < 100; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_a     = 10'd1000;
            bus.sample_b     = 10'd5;
            tick();
            total++;
            if (bus.full !== 1'b0 || bus.capturing !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_no_capture: full=%0b capturing=%0b expected 0/0", bus.full, bus.capturing);
            end
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_trigger_threshold();
        bus.threshold = 10'd100;
        bus.arm       = 1'b1;
        tick();
        bus.arm = 1'b0;
        total++;
        if (bus.count !== 12'd0 || bus.capturing !== 1'b0) begin
            bad++;
            $display("[TB] FAIL armed_state: count=%0d capturing=%0b expected 0/0", bus.count, bus.capturing);
        end

        bus.sample_valid = 1'b1;
        bus.sample_a     = 10'd612;
        bus.sample_b     = 10'd512;
        tick();
        total++;
        if (bus.capturing !== 1'b0) begin
            bad++;
            $display("[TB] FAIL equal_no_trigger: capturing=%0b expected 0", bus.capturing);
        end

        bus.sample_a = 10'd512;
        bus.sample_b = 10'd411;
        tick();
        bus.sample_valid = 1'b0;
        total++;
        if (bus.capturing !== 1'b1 || bus.count !== 12'd1) begin
            bad++;
            $display("[TB] FAIL trigger_fires: capturing=%0b count=%0d expected 1/1", bus.capturing, bus.count);
        end
    endtask

    // Ramp fill with valid low one cycle in three; arm at count 500 must be ignored.
    task automatic test_full_capture();
        int n;
        int c;
        n = 1;
        c = 0;
        while (n <= 1999) begin
            bus.sample_valid = (c % 3) != 2;
            bus.sample_a     = ramp_a(n);
            bus.sample_b     = ramp_b(n);
            bus.arm          = bus.sample_valid && (n == 500);
            if (bus.sample_valid && n == 1999) begin
                total++;
                if (bus.full !== 1'b0 || bus.count !== 12'd1999) begin
                    bad++;
                    $display("[TB] FAIL before_last_write: full=%0b count=%0d expected 0/1999", bus.full, bus.count);
                end
            end
            tick();
            if (bus.arm) begin
                total++;
                if (bus.capturing !== 1'b1 || bus.count !== 12'd501) begin
                    bad++;
                    $display("[TB] FAIL arm_in_capture: capturing=%0b count=%0d expected 1/501", bus.capturing, bus.count);
                end
            end
            if (bus.sample_valid) n++;
            c++;
        end
        bus.arm          = 1'b0;
        bus.sample_valid = 1'b0;
        total++;
        if (bus.full !== 1'b1 || bus.count !== 12'd2000 || bus.capturing !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_after_last: full=%0b count=%0d capturing=%0b expected 1/2000/0",
                     bus.full, bus.count, bus.capturing);
        end

        for (int i = 0; i < 5; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_a     = 10'd7;
            bus.sample_b     = 10'd7;
            tick();
        end
        bus.sample_valid = 1'b0;
        total++;
        if (bus.full !== 1'b1 || bus.count !== 12'd2000) begin
            bad++;
            $display("[TB] FAIL full_holds: full=%0b count=%0d expected 1/2000", bus.full, bus.count);
        end
    endtask

    // Sweep every address each cycle; data for address i appears one edge later.
    task automatic test_read_port();
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        bus.rd_addr = '0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            bus.rd_addr = 12'(i + 1);
            if (i == 0) begin
                exp_a = 10'd512;
                exp_b = 10'd411;
            end else if (i < 2000) begin
                exp_a = ramp_a(i);
                exp_b = ramp_b(i);
            end else begin
                exp_a = 10'd0;
                exp_b = 10'd0;
            end
            total++;
            if (bus.rd_a !== exp_a || bus.rd_b !== exp_b) begin
                bad++;
                $display("[TB] FAIL read_addr_%0d: got a=%0d b=%0d expected a=%0d b=%0d",
                         i, bus.rd_a, bus.rd_b, exp_a, exp_b);
            end
        end
        bus.rd_addr = '0;
    endtask

    task automatic test_rearm_in_full();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        total++;
        if (bus.full !== 1'b0 || bus.count !== 12'd0 || bus.capturing !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rearm_full: full=%0b count=%0d capturing=%0b expected 0/0/0",
                     bus.full, bus.count, bus.capturing);
        end
    endtask

    task automatic test_reset_mid_capture();
        bus.sample_valid = 1'b1;
        bus.sample_a     = 10'd1000;
        bus.sample_b     = 10'd512;
        tick();
        for (int n = 1; n < 1200; n++) begin
            bus.sample_a = ramp_a(n);
            bus.sample_b = ramp_b(n);
            tick();
        end
        bus.sample_valid = 1'b0;
        total++;
        if (bus.capturing !== 1'b1 || bus.count !== 12'd1200) begin
            bad++;
            $display("[TB] FAIL mid_capture: capturing=%0b count=%0d expected 1/1200", bus.capturing, bus.count);
        end

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++;
        if (bus.capturing !== 1'b0 || bus.full !== 1'b0 || bus.count !== 12'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid: capturing=%0b full=%0b count=%0d expected 0/0/0",
                     bus.capturing, bus.full, bus.count);
        end

        bus.arm = 1'b1;
        tick();
        // Trigger with arm held: the trigger must win.
        bus.sample_valid = 1'b1;
        bus.sample_a     = 10'd20;
        bus.sample_b     = 10'd512;
        tick();
        bus.arm = 1'b0;
        total++;
        if (bus.capturing !== 1'b1 || bus.count !== 12'd1) begin
            bad++;
            $display("[TB] FAIL trigger_beats_arm: capturing=%0b count=%0d expected 1/1", bus.capturing, bus.count);
        end
        for (int n = 1; n < 2000; n++) begin
            bus.sample_a = ramp_a(n);
            bus.sample_b = ramp_b(n);
            tick();
        end
        bus.sample_valid = 1'b0;
        total++;
        if (bus.full !== 1'b1) begin
            bad++;
            $display("[TB] FAIL refill_full: full=%0b expected 1", bus.full);
        end

        bus.rd_addr = 12'd0;
        tick();
        bus.rd_addr = 12'd1;
        total++;
        if (bus.rd_a !== 10'd20 || bus.rd_b !== 10'd512) begin
            bad++;
            $display("[TB] FAIL refill_addr0: got a=%0d b=%0d expected a=20 b=512", bus.rd_a, bus.rd_b);
        end
        tick();
        total++;
        if (bus.rd_a !== ramp_a(1) || bus.rd_b !== ramp_b(1)) begin
            bad++;
            $display("[TB] FAIL refill_addr1: got a=%0d b=%0d expected a=%0d b=%0d",
                     bus.rd_a, bus.rd_b, ramp_a(1), ramp_b(1));
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset_n          = 1'b0;
        bus.arm          = 1'b0;
        bus.threshold    = '0;
        bus.sample_valid = 1'b0;
        bus.sample_a     = '0;
        bus.sample_b     = '0;
        bus.rd_addr      = '0;
        test_reset();
        test_trigger_threshold();
        test_full_capture();
        test_read_port();
        test_rearm_in_full();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_sample_capture.md
# dual_sample_capture

Two-channel sample capture buffer that sits directly upstream of the cross-correlation stage. It accepts paired 10-bit ADC samples (microphone A and B) and waits, once armed, for either channel to exceed a trigger threshold around midscale. It then stores exactly DEPTH consecutive sample pairs and raises `full`. While full, it serves the stored samples to the correlator through a registered random-access read port.

## Interface
- DEPTH, 2000, sample pairs stored per capture
- W, 10, sample width (unsigned ADC code)
- ADDR_W, 12, address/count width (matches correlator index width)
- MIDSCALE, 512, ADC code for zero signal

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset; one clock, reset is synchronous and active-low
- arm  in  1  single-cycle pulse; starts or restarts a capture
- threshold  in  W  trigger magnitude, compared against abs(sample − MIDSCALE)
- sample_valid  in  1  qualifies sample_a/sample_b this cycle
- sample_a  in  W  channel A sample
- sample_b  in  W  channel B sample
- rd_addr  in  ADDR_W  read address from correlator
- rd_a  out  W  channel A sample at rd_addr, one cycle later
- rd_b  out  W  channel B sample at rd_addr, one cycle later
- count  out  ADDR_W  number of pairs stored in current capture
- capturing  out  1  high in CAPTURE
- full  out  1  high in FULL; correlator may start

## Operation
- States: IDLE, ARMED, CAPTURE, FULL.
- IDLE → ARMED on `arm`. `count` clears to 0.
- In ARMED, a sample triggers when `sample_valid` is high and either channel has abs(sample − MIDSCALE) > threshold.
  - Magnitude is computed in W+1-bit signed arithmetic. Equality does not trigger.
  - The triggering pair is written at address 0. `count` becomes 1. Next state is CAPTURE.
- In CAPTURE, each valid pair is written at address `count`, then `count` increments.
  - The write of address DEPTH−1 moves the FSM to FULL next cycle, with `count` = DEPTH.
- In FULL, writes are ignored and memory holds.
- `arm` in FULL or ARMED returns to ARMED and clears `count` to 0.
- `arm` in CAPTURE is ignored. A capture is never truncated.
- `arm` and a triggering sample in the same cycle in ARMED: the trigger wins and the sample is stored. `arm` is ignored.
- Read port:
  - `rd_a`/`rd_b` are registered and valid in every state; contents are meaningful only in FULL.
  - rd_addr ≥ DEPTH returns 0 on both outputs.
- threshold is sampled every cycle. It must be held stable by the producer while ARMED.

## Timing
- Reset values: state IDLE, count 0, capturing 0, full 0, rd_a 0, rd_b 0. Memory contents are not cleared.
- Reset asserted mid-capture: IDLE on the next edge, full/capturing low. Partial data is abandoned.
- Read latency: exactly 1 cycle from rd_addr to rd_a/rd_b. Back-to-back reads are allowed every cycle.
- Write: same cycle as the accepted `sample_valid`. No backpressure; every valid sample in CAPTURE is stored.
- `full` rises the cycle after the DEPTH-th write. It stays high until `arm` or reset.
- Trigger decision is combinational on the current sample. No pre-trigger history.

## Structure
- Shared package `capture_pkg`:
  - `capture_state_t` enum (2 bits)
  - DEPTH, W, ADDR_W, MIDSCALE defaults
  - these constants are shared with the correlator
- Sub-module `sample_ram`:
  - one-write/one-read synchronous RAM of DEPTH × W
  - instantiated twice, once per channel
  - must infer block RAM
  - out-of-range read masking lives in the parent.

## Test plan
- **Reset:** hold reset_n low with random inputs → all outputs 0; state IDLE. Release with no arm and 100 valid samples → full stays 0.
- **Trigger threshold:** arm, threshold=100.
  - Feed A=612, B=512 → no trigger (difference 100 is not > 100).
  - Then A=512, B=411 → trigger. rd at addr 0 after FULL returns A=512, B=411.
- **Full capture:** after trigger, feed 1999 further valid ramp samples with A=n, B=1023−n, with sample_valid gapped 1-in-3.
  - full asserts exactly one cycle after the 2000th write; count=2000.
  - Reading addr 1999 returns the last pair.
  - Further valid samples do not change memory.
- **Read port:** in FULL, sweep rd_addr 0..2047 every cycle.
  - Data lags by 1 cycle.
  - addr 2000..2047 returns 0.
- **Re-arm and ignore:** arm mid-CAPTURE at count=500 → ignored, full still asserts at 2000. Then arm in FULL → full drops next cycle, count=0, state ARMED.
- **Reset mid-operation:** reset_n low at count=1200 → IDLE, capturing=0. A new arm plus trigger starts again at address 0.
